// File: rtl/jtkiwi_linebuf_if.sv
// Drawer-side bus of the object line buffer: pixel writes in, clear/line status out.
interface jtkiwi_linebuf_if #(
   parameter int unsigned AW = 9,
   parameter int unsigned DW = 9
);
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_data;
   logic          buf_we;
   logic          busy;
   logic          line_start;

   modport master (
      output buf_addr, buf_data, buf_we,
      input  busy, line_start
   );

   modport slave (
      input  buf_addr, buf_data, buf_we,
      output busy, line_start
   );
endinterface

// File: rtl/jtkiwi_linebuf.sv
// Double-buffered object line buffer: the drawer fills one bank while the other is
// read out at pixel rate and erased behind the read pointer; banks swap on HS rising.
module jtkiwi_linebuf #(
   parameter int unsigned    AW      = 9,
   parameter int unsigned    DW      = 9,
   parameter logic [AW-1:0]  HOFFSET = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pxl_cen,
   input  logic            LHBL,
   input  logic            HS,
   jtkiwi_linebuf_if.slave drw,
   output logic [DW-1:0]   col_addr
);

   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          wr_bank_q, wr_bank_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [DW-1:0] col_addr_q, col_addr_d;
   logic          busy_q, busy_d;
   logic          line_start_q, line_start_d;
   logic          ers_pend_q, ers_pend_d;
   logic [AW-1:0] ers_addr_q, ers_addr_d;
   logic          ers_bank_q, ers_bank_d;
   logic          hs_l_q;

   logic [DW-1:0] mem0 [DEPTH];
   logic [DW-1:0] mem1 [DEPTH];

   logic          we0, we1;
   logic [AW-1:0] wa0, wa1;
   logic [DW-1:0] wd0, wd1;
   logic          rd_bank;
   logic [DW-1:0] rd_data;
   logic          drw_wr;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_CLEAR;
         clr_addr_q   <= '0;
         wr_bank_q    <= 1'b0;
         rd_addr_q    <= HOFFSET;
         col_addr_q   <= '0;
         busy_q       <= 1'b1;
         line_start_q <= 1'b0;
         ers_pend_q   <= 1'b0;
         ers_addr_q   <= '0;
         ers_bank_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         wr_bank_q    <= wr_bank_d;
         rd_addr_q    <= rd_addr_d;
         col_addr_q   <= col_addr_d;
         busy_q       <= busy_d;
         line_start_q <= line_start_d;
         ers_pend_q   <= ers_pend_d;
         ers_addr_q   <= ers_addr_d;
         ers_bank_q   <= ers_bank_d;
      end
   end

   // HS history follows the pin even through reset, so a held-high HS never looks like an edge
   always_ff @(posedge clk) begin
      hs_l_q <= HS;
   end

   // Next state, bank port steering and read side
   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      wr_bank_d    = wr_bank_q;
      rd_addr_d    = rd_addr_q;
      col_addr_d   = col_addr_q;
      line_start_d = 1'b0;
      ers_pend_d   = 1'b0;
      ers_addr_d   = ers_addr_q;
      ers_bank_d   = ers_bank_q;
      we0          = 1'b0;
      we1          = 1'b0;
      wa0          = '0;
      wa1          = '0;
      wd0          = '0;
      wd1          = '0;
      rd_bank      = ~wr_bank_q;
      rd_data      = rd_bank ? mem1[rd_addr_q] : mem0[rd_addr_q];
      drw_wr       = drw.buf_we && (drw.buf_data[3:0] != 4'd0);

      case (state_q)
         ST_CLEAR: begin
            we0        = 1'b1;
            we1        = 1'b1;
            wa0        = clr_addr_q;
            wa1        = clr_addr_q;
            col_addr_d = '0;
            clr_addr_d = clr_addr_q + AW'(1);
            if (clr_addr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (HS && !hs_l_q) begin
               wr_bank_d    = ~wr_bank_q;
               line_start_d = 1'b1;
            end
            if (!LHBL) begin
               rd_addr_d = HOFFSET;
               if (pxl_cen) col_addr_d = '0;
            end else if (pxl_cen) begin
               col_addr_d = rd_data;
               rd_addr_d  = rd_addr_q + AW'(1);
               ers_pend_d = 1'b1;
               ers_addr_d = rd_addr_q;
               ers_bank_d = rd_bank;
            end
            // Erase targets the bank that was actually read, even across a swap
            if (ers_pend_q) begin
               if (ers_bank_q) begin
                  we1 = 1'b1;
                  wa1 = ers_addr_q;
               end else begin
                  we0 = 1'b1;
                  wa0 = ers_addr_q;
               end
            end
            if (drw_wr) begin
               if (wr_bank_q) begin
                  we1 = 1'b1;
                  wa1 = drw.buf_addr;
                  wd1 = drw.buf_data;
               end else begin
                  we0 = 1'b1;
                  wa0 = drw.buf_addr;
                  wd0 = drw.buf_data;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase

      busy_d = (state_d == ST_CLEAR);
   end

   // Bank RAMs, one write port each
   always_ff @(posedge clk) begin
      if (rst_n && we0) mem0[wa0] <= wd0;
      if (rst_n && we1) mem1[wa1] <= wd1;
   end

   assign col_addr       = col_addr_q;
   assign drw.busy       = busy_q;
   assign drw.line_start = line_start_q;

endmodule

// File: tb/tb_jtkiwi_linebuf.sv
// Scoreboard bench for jtkiwi_linebuf: stimulus queues expected pixels, a monitor checks col_addr.
module tb_jtkiwi_linebuf;

   localparam int unsigned AW   = 9;
   localparam int unsigned DW   = 9;
   localparam int unsigned NPIX = 512;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          pxl_cen = 1'b0;
   logic          LHBL    = 1'b0;
   logic          HS      = 1'b0;
   logic [DW-1:0] col_addr;

   always #5 clk = ~clk;

   jtkiwi_linebuf_if #(.AW(AW), .DW(DW)) drw_if ();

   jtkiwi_linebuf #(.AW(AW), .DW(DW), .HOFFSET(9'd0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pxl_cen  (pxl_cen),
      .LHBL     (LHBL),
      .HS       (HS),
      .drw      (drw_if),
      .col_addr (col_addr)
   );

   int            n_cmp   = 0;
   int            n_err   = 0;
   bit            mon_en  = 1'b0;
   int            pix_idx = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] line_exp [NPIX];

   task automatic check(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: every active-line pixel strobe produces one col_addr sample to compare
   always @(posedge clk) begin
      if (mon_en && pxl_cen && LHBL && rst_n) begin
         #1;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pixel %0d: got 0x%0h with no expected value queued", pix_idx, col_addr);
         end else begin
            check($sformatf("pixel %0d", pix_idx), int'(col_addr), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic clear_exp();
      for (int i = 0; i < NPIX; i++) line_exp[i] = '0;
   endtask

   task automatic write_px(input int x, input int d);
      @(negedge clk);
      drw_if.buf_we   = 1'b1;
      drw_if.buf_addr = AW'(x);
      drw_if.buf_data = DW'(d);
      @(negedge clk);
      drw_if.buf_we   = 1'b0;
   endtask

   // HS pulse, optionally with a drawer write in the swap clk
   task automatic hs_pulse(input bit wr, input int x, input int d);
      @(negedge clk);
      HS              = 1'b1;
      drw_if.buf_we   = wr;
      drw_if.buf_addr = AW'(x);
      drw_if.buf_data = DW'(d);
      @(posedge clk);
      #1 check("line_start_on_swap", int'(drw_if.line_start), 1);
      @(negedge clk);
      HS            = 1'b0;
      drw_if.buf_we = 1'b0;
      @(posedge clk);
      #1 check("line_start_one_clk", int'(drw_if.line_start), 0);
   endtask

   // Active line of npx pixels, pxl_cen every other clk; leaves LHBL high if cut short
   task automatic read_line(input int npx);
      @(negedge clk);
      LHBL = 1'b0;
      @(negedge clk);
      @(negedge clk);
      LHBL   = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < npx; i++) begin
         pxl_cen = 1'b1;
         pix_idx = i;
         exp_q.push_back(line_exp[i]);
         @(negedge clk);
         pxl_cen = 1'b0;
         @(negedge clk);
      end
      mon_en = 1'b0;
      if (npx == int'(NPIX)) begin
         LHBL = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   // Count busy-high samples from the current negedge; optionally toggle HS/pxl_cen meanwhile
   task automatic count_busy(input bit wiggle, output int cnt, output bit ls_seen, output bit col_nz);
      cnt     = 0;
      ls_seen = 1'b0;
      col_nz  = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (!drw_if.busy) break;
         cnt++;
         if (drw_if.line_start) ls_seen = 1'b1;
         if (col_addr != '0) col_nz = 1'b1;
         if (wiggle) begin
            HS      = c[4];
            pxl_cen = c[0];
         end
         @(negedge clk);
      end
      HS      = 1'b0;
      pxl_cen = 1'b0;
   endtask

   initial begin
      int cnt;
      bit ls_seen;
      bit col_nz;

      drw_if.buf_we   = 1'b0;
      drw_if.buf_addr = '0;
      drw_if.buf_data = '0;
      clear_exp();

      // Power-up reset and clear
      repeat (3) @(negedge clk);
      check("reset_busy", int'(drw_if.busy), 1);
      check("reset_line_start", int'(drw_if.line_start), 0);
      check("reset_col_addr", int'(col_addr), 0);
      rst_n = 1'b1;
      count_busy(1'b0, cnt, ls_seen, col_nz);
      check("clear_busy_clks", cnt, 512);
      read_line(NPIX);

      // Draw and display
      write_px(10, 9'h1A5);
      hs_pulse(1'b0, 0, 0);
      clear_exp();
      line_exp[10] = 9'h1A5;
      read_line(NPIX);

      // Erase-after-read: same bank shown again after two swaps
      hs_pulse(1'b0, 0, 0);
      hs_pulse(1'b0, 0, 0);
      clear_exp();
      read_line(NPIX);

      // Transparency and last-write-wins
      write_px(20, 9'h0F3);
      write_px(20, 9'h120);
      write_px(30, 9'h0F3);
      write_px(30, 9'h0F4);
      hs_pulse(1'b0, 0, 0);
      clear_exp();
      line_exp[20] = 9'h0F3;
      line_exp[30] = 9'h0F4;
      read_line(NPIX);

      // Write in the swap clk lands in the bank read next
      hs_pulse(1'b1, 5, 9'h033);
      clear_exp();
      line_exp[5] = 9'h033;
      read_line(NPIX);

      // Mid-line reset at pixel 100
      write_px(99, 9'h0A7);
      hs_pulse(1'b0, 0, 0);
      clear_exp();
      line_exp[99] = 9'h0A7;
      read_line(100);
      rst_n = 1'b0;
      @(posedge clk);
      #1 check("midreset_col_addr", int'(col_addr), 0);
      check("midreset_busy", int'(drw_if.busy), 1);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy(1'b1, cnt, ls_seen, col_nz);
      LHBL = 1'b0;
      check("midreset_busy_clks", cnt, 512);
      check("midreset_hs_ignored", int'(ls_seen), 0);
      check("midreset_col_held", int'(col_nz), 0);

      // After the restart clear: bank 0 is the write bank again
      write_px(7, 9'h055);
      hs_pulse(1'b0, 0, 0);
      clear_exp();
      line_exp[7] = 9'h055;
      read_line(NPIX);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
